mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_iter_step.sv | 44 ++++
 rtl/mult_div_unit.sv | 137 +++++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared constants for the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [5:0] C_FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] C_FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] C_FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] C_FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] C_FUNCT_MULT  = 6'h18;
    localparam logic [5:0] C_FUNCT_MULTU = 6'h19;
    localparam logic [5:0] C_FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] C_FUNCT_DIVU  = 6'h1B;

    localparam int C_STATE_W = 2;
    localparam logic [C_STATE_W-1:0] C_ST_IDLE = 2'd0;
    localparam logic [C_STATE_W-1:0] C_ST_RUN  = 2'd1;
    localparam logic [C_STATE_W-1:0] C_ST_FIX  = 2'd2;

    localparam int C_ITER_COUNT = 32;
    localparam int C_CNT_W      = 5;
    localparam logic [C_CNT_W-1:0] C_LAST_ITER = C_CNT_W'(C_ITER_COUNT - 1);

    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic isSigned);
        return (isSigned && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_step
// Description : One combinational shift-add multiply or restoring divide step.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter_step
    import mdu_pkg::*;
(
    input  logic        isDiv,
    input  logic [31:0] accHi,
    input  logic [31:0] accLo,
    input  logic [31:0] operand,
    output logic [31:0] nextHi,
    output logic [31:0] nextLo
);

    logic [32:0] w_addSum;
    logic [32:0] w_trialRem;
    logic        w_fits;
    logic [31:0] w_subRem;

    // Multiply: accLo holds the remaining multiplier bits, shifted out LSB first.
    assign w_addSum   = {1'b0, accHi} + {1'b0, (accLo[0] ? operand : 32'd0)};

    // Divide: the remainder is kept below the divisor, so the difference fits 32 bits.
    assign w_trialRem = {accHi, accLo[31]};
    assign w_fits     = (w_trialRem >= {1'b0, operand});
    assign w_subRem   = w_trialRem[31:0] - operand;

    always_comb begin
        nextHi = '0;
        nextLo = '0;
        if (isDiv) begin
            nextHi = w_fits ? w_subRem : w_trialRem[31:0];
            nextLo = {accLo[30:0], w_fits};
        end else begin
            nextHi = w_addSum[32:1];
            nextLo = {w_addSum[0], accLo[31:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : 34-cycle iterative MULT/DIV unit with HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [5:0]  Funct,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic [31:0] MfOut
);

    logic [C_STATE_W-1:0] r_state;
    logic [C_CNT_W-1:0]   r_iterCnt;
    logic                 r_done;
    logic                 r_isDiv;
    logic                 r_negMain;
    logic                 r_negRem;
    logic                 r_divZero;
    logic [31:0]          r_opA;
    logic [31:0]          r_operand;
    logic [31:0]          r_accHi;
    logic [31:0]          r_accLo;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;

    logic                 w_isMulDiv;
    logic                 w_isDivFunct;
    logic                 w_signedOp;
    logic [31:0]          w_nextHi;
    logic [31:0]          w_nextLo;
    logic [63:0]          w_product;
    logic [31:0]          w_quot;
    logic [31:0]          w_rem;

    assign w_isMulDiv   = (Funct == C_FUNCT_MULT) || (Funct == C_FUNCT_MULTU) ||
                          (Funct == C_FUNCT_DIV)  || (Funct == C_FUNCT_DIVU);
    assign w_isDivFunct = (Funct == C_FUNCT_DIV)  || (Funct == C_FUNCT_DIVU);
    assign w_signedOp   = (Funct == C_FUNCT_MULT) || (Funct == C_FUNCT_DIV);

    mdu_iter_step u_step (
        .isDiv   (r_isDiv),
        .accHi   (r_accHi),
        .accLo   (r_accLo),
        .operand (r_operand),
        .nextHi  (w_nextHi),
        .nextLo  (w_nextLo)
    );

    // Sign fix-up of the magnitude result; the most-negative quotient wraps to itself.
    assign w_product = r_negMain ? (~{r_accHi, r_accLo} + 64'd1) : {r_accHi, r_accLo};
    assign w_quot    = r_negMain ? (~r_accLo + 32'd1) : r_accLo;
    assign w_rem     = r_negRem  ? (~r_accHi + 32'd1) : r_accHi;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= C_ST_IDLE;
            r_iterCnt <= '0;
            r_done    <= 1'b0;
            r_isDiv   <= 1'b0;
            r_negMain <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_opA     <= '0;
            r_operand <= '0;
            r_accHi   <= '0;
            r_accLo   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                C_ST_IDLE: begin
                    if (Start && w_isMulDiv) begin
                        r_isDiv   <= w_isDivFunct;
                        r_negMain <= w_signedOp && (OpA[31] ^ OpB[31]);
                        r_negRem  <= w_signedOp && OpA[31];
                        r_divZero <= (OpB == 32'd0);
                        r_opA     <= OpA;
                        r_operand <= magnitude(OpB, w_signedOp);
                        r_accHi   <= '0;
                        r_accLo   <= magnitude(OpA, w_signedOp);
                        r_iterCnt <= '0;
                        r_state   <= C_ST_RUN;
                    end else if (Start && (Funct == C_FUNCT_MTHI)) begin
                        r_hi <= OpA;
                    end else if (Start && (Funct == C_FUNCT_MTLO)) begin
                        r_lo <= OpA;
                    end
                end
                C_ST_RUN: begin
                    r_accHi   <= w_nextHi;
                    r_accLo   <= w_nextLo;
                    r_iterCnt <= r_iterCnt + 1'b1;
                    if (r_iterCnt == C_LAST_ITER) begin
                        r_state <= C_ST_FIX;
                    end
                end
                C_ST_FIX: begin
                    if (!r_isDiv) begin
                        r_hi <= w_product[63:32];
                        r_lo <= w_product[31:0];
                    end else if (r_divZero) begin
                        r_hi <= r_opA;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                    r_done  <= 1'b1;
                    r_state <= C_ST_IDLE;
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign Busy  = (r_state != C_ST_IDLE);
    assign Done  = r_done;
    assign HiOut = r_hi;
    assign LoOut = r_lo;
    assign MfOut = (Funct == C_FUNCT_MFHI) ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [5:0]  Funct;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        Busy;
    logic        Done;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic [31:0] MfOut;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          doneCyc;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .Funct (Funct),
        .OpA   (OpA),
        .OpB   (OpB),
        .Busy  (Busy),
        .Done  (Done),
        .HiOut (HiOut),
        .LoOut (LoOut),
        .MfOut (MfOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && Done) begin
            if (expQ.size() == 0) begin
                check("done_without_request", {31'd0, Done}, 32'd0);
            end else begin
                e = expQ.pop_front();
                check("result_hi", HiOut, e.hi);
                check("result_lo", LoOut, e.lo);
                check("done_cycle", 32'(cyc), 32'(e.doneCyc));
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 60 && expQ.size() != 0; i++) @(negedge clk);
        check({name, "_drain"}, 32'(expQ.size()), 32'd0);
    endtask

    // Start is high in cycle 0; Busy must cover cycles 1-33 and drop in cycle 34.
    task automatic doOp(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo);
        int busyLow = 0;
        @(negedge clk);
        Funct = f; OpA = a; OpB = b; Start = 1'b1;
        expQ.push_back('{hi: eHi, lo: eLo, doneCyc: cyc + 34});
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            Start = 1'b0;
            Funct = 6'h00;
            if (!Busy) busyLow++;
        end
        check({name, "_busy_low_cycles"}, 32'(busyLow), 32'd0);
        @(negedge clk);
        check({name, "_busy_after"}, {31'd0, Busy}, 32'd0);
        drain(name);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int doneSeen;
        reset = 1'b1; Start = 1'b0; Funct = 6'h00; OpA = '0; OpB = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_hi", HiOut, 32'd0);
        check("reset_lo", LoOut, 32'd0);
        reset = 1'b0;

        doOp("multu_max", C_FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        doOp("mult_neg",  C_FUNCT_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        doOp("mult_min",  C_FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        doOp("div_neg",   C_FUNCT_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        doOp("divu_big",  C_FUNCT_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC);
        doOp("divu_zero", C_FUNCT_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
        doOp("div_zero",  C_FUNCT_DIV,   32'hFFFF_FFF6, 32'h0000_0000, 32'hFFFF_FFF6, 32'hFFFF_FFFF);
        doOp("div_ovf",   C_FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Start requests while busy (MULT in cycle 5, MTHI in cycle 6) must be ignored.
        @(negedge clk);
        Funct = C_FUNCT_DIVU; OpA = 32'd100; OpB = 32'd7; Start = 1'b1;
        expQ.push_back('{hi: 32'd2, lo: 32'd14, doneCyc: cyc + 34});
        @(negedge clk);
        Start = 1'b0;
        repeat (4) @(negedge clk);
        Funct = C_FUNCT_MULT; OpA = 32'hFFFF_FFFF; OpB = 32'd3; Start = 1'b1;
        @(negedge clk);
        Funct = C_FUNCT_MTHI; OpA = 32'hDEAD_BEEF;
        @(negedge clk);
        Start = 1'b0; Funct = 6'h00;
        drain("busy_ignore");

        // Reset in cycle 10 of an operation abandons it with no Done pulse.
        @(negedge clk);
        Funct = C_FUNCT_MULTU; OpA = 32'd3; OpB = 32'd5; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; Funct = 6'h00;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HiOut, 32'd0);
        check("abort_lo", LoOut, 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) doneSeen++;
        end
        check("abort_no_done", 32'(doneSeen), 32'd0);

        // MTHI/MTLO writes and MFHI/MFLO reads.
        @(negedge clk);
        Funct = C_FUNCT_MTHI; OpA = 32'h1234_5678; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; Funct = C_FUNCT_MFHI;
        #1;
        check("mfhi_value", MfOut, 32'h1234_5678);
        check("mthi_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        Funct = C_FUNCT_MTLO; OpA = 32'h0BAD_F00D; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; Funct = C_FUNCT_MFLO;
        #1;
        check("mflo_value", MfOut, 32'h0BAD_F00D);
        check("mtlo_busy", {31'd0, Busy}, 32'd0);
        check("mtlo_hi_kept", HiOut, 32'h1234_5678);

        // Unsupported Funct with Start leaves everything alone.
        @(negedge clk);
        Funct = 6'h20; OpA = 32'hFFFF_FFFF; OpB = 32'd1; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; Funct = C_FUNCT_MFHI;
        #1;
        check("ignored_busy", {31'd0, Busy}, 32'd0);
        check("ignored_hi", HiOut, 32'h1234_5678);
        check("ignored_lo", LoOut, 32'h0BAD_F00D);
        check("ignored_mf", MfOut, 32'h1234_5678);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
